// File: rtl/multi_div_gen.sv
// multi_div_gen: CH independent programmable clock dividers.
// Each channel counts 0..div and produces a terminal event every div+1 enabled
// cycles.  The channel mode decides how that event shapes the op output.
// Channels are reprogrammed through a valid/ready config port that takes at
// most one request every two cycles.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous, active-high reset
//   en         global count enable
//   cfg_valid  config request
//   cfg_ready  config can be accepted (low for one cycle after each accept)
//   cfg_ch     target channel of the request
//   cfg_div    terminal count to load
//   cfg_mode   00 OFF, 01 TOGGLE, 10 PULSE, 11 ONESHOT
//   op         per-channel waveform output (registered)
//   tick       per-channel one-cycle terminal-count strobe (registered)
//   cfg_err    one-cycle strobe: an accepted request named a channel >= CH
module multi_div_gen #(
  parameter int CH = 4,
  parameter int W  = 8,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_ch,
  input  logic [W-1:0]  cfg_div,
  input  logic [1:0]    cfg_mode,
  output logic [CH-1:0] op,
  output logic [CH-1:0] tick,
  output logic          cfg_err
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_TOGGLE  = 2'b01,
    MODE_PULSE   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_t;

  // One extra bit so that CH itself is representable when CH == 2**CW.
  localparam logic [CW:0] CH_L = (CW+1)'(CH);

  logic accept;
  logic cfg_bad;

  assign accept  = cfg_valid && cfg_ready;
  assign cfg_bad = ({1'b0, cfg_ch} >= CH_L);

  // Handshake: ready drops for exactly the cycle after an accept.  During
  // reset ready is 0, and the first edge after release raises it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_ready <= !accept;
      cfg_err   <= accept && cfg_bad;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [W-1:0] cnt_reg;
      logic [W-1:0] div_reg;
      mode_t        mode_reg;
      logic         op_reg;
      logic         tick_reg;
      logic         hit;

      // cfg_ch can only equal gi when it is in range, so an out-of-range
      // request never touches any channel.
      assign hit = accept && (cfg_ch == CW'(gi));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg  <= '0;
          div_reg  <= '0;
          mode_reg <= MODE_OFF;
          op_reg   <= 1'b0;
          tick_reg <= 1'b0;
        end else if (hit) begin
          // A config takes priority over a coinciding terminal event.
          div_reg  <= cfg_div;
          mode_reg <= mode_t'(cfg_mode);
          cnt_reg  <= '0;
          op_reg   <= 1'b0;
          tick_reg <= 1'b0;
        end else if (mode_reg == MODE_OFF) begin
          cnt_reg  <= '0;
          op_reg   <= 1'b0;
          tick_reg <= 1'b0;
        end else if (!en) begin
          // Frozen: count and waveform hold.  In PULSE the waveform is the
          // strobe itself, so it falls together with tick.
          tick_reg <= 1'b0;
          if (mode_reg == MODE_PULSE) begin
            op_reg <= 1'b0;
          end
        end else if (cnt_reg == div_reg) begin
          cnt_reg  <= '0;
          tick_reg <= 1'b1;
          case (mode_reg)
            MODE_TOGGLE:  op_reg <= ~op_reg;
            MODE_PULSE:   op_reg <= 1'b1;
            MODE_ONESHOT: begin
              op_reg   <= 1'b1;
              mode_reg <= MODE_OFF;
            end
            default:      op_reg <= 1'b0;
          endcase
        end else begin
          cnt_reg  <= cnt_reg + W'(1);
          tick_reg <= 1'b0;
          if (mode_reg != MODE_TOGGLE) begin
            op_reg <= 1'b0;
          end
        end
      end

      assign op[gi]   = op_reg;
      assign tick[gi] = tick_reg;
    end
  endgenerate

endmodule

// File: tb/tb_multi_div_gen.sv
// Directed bench for multi_div_gen (CH=4, W=8, CW=3 so out-of-range channel
// numbers can be driven).  A cycle table covers configuration, TOGGLE, PULSE,
// ONESHOT and the handshake; hand-written sequences cover enable freeze,
// reconfiguration on a terminal edge, the cfg_ch == CH boundary and
// asynchronous reset.
module tb_multi_div_gen;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int CW = 3;

  logic          clk;
  logic          reset;
  logic          en;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_ch;
  logic [W-1:0]  cfg_div;
  logic [1:0]    cfg_mode;
  logic [CH-1:0] op;
  logic [CH-1:0] tick;
  logic          cfg_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  multi_div_gen #(.CH(CH), .W(W), .CW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_mode (cfg_mode),
    .op       (op),
    .tick     (tick),
    .cfg_err  (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       v;
    logic [2:0] ch;
    logic [7:0] dv;
    logic [1:0] md;
    logic [3:0] op;
    logic [3:0] tick;
    logic       rdy;
    logic       err;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic v, input logic [2:0] c,
                       input logic [7:0] d, input logic [1:0] m);
    en        = e;
    cfg_valid = v;
    cfg_ch    = c;
    cfg_div   = d;
    cfg_mode  = m;
  endtask

  initial begin
    //          en  v  ch dv  md  op       tick     rdy err
    tbl[0]  = '{0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1, 0};
    tbl[1]  = '{1, 1, 0, 3, 1, 4'b0000, 4'b0000, 0, 0}; // ch0 div3 TOGGLE accepted
    tbl[2]  = '{1, 1, 1, 0, 2, 4'b0000, 4'b0000, 1, 0}; // ready low: ignored
    tbl[3]  = '{1, 1, 1, 0, 2, 4'b0000, 4'b0000, 0, 0}; // ch1 div0 PULSE accepted
    tbl[4]  = '{1, 0, 0, 0, 0, 4'b0010, 4'b0010, 1, 0};
    tbl[5]  = '{1, 1, 2, 5, 3, 4'b0011, 4'b0011, 0, 0}; // ch2 div5 ONESHOT; ch0 fires
    tbl[6]  = '{1, 1, 7, 9, 1, 4'b0011, 4'b0010, 1, 0}; // ready low: ignored
    tbl[7]  = '{1, 1, 7, 9, 1, 4'b0011, 4'b0010, 0, 1}; // ch7 accepted -> cfg_err
    tbl[8]  = '{1, 0, 0, 0, 0, 4'b0011, 4'b0010, 1, 0};
    tbl[9]  = '{1, 0, 0, 0, 0, 4'b0010, 4'b0011, 1, 0}; // ch0 toggles low
    tbl[10] = '{1, 0, 0, 0, 0, 4'b0010, 4'b0010, 1, 0};
    tbl[11] = '{1, 0, 0, 0, 0, 4'b0110, 4'b0110, 1, 0}; // ch2 oneshot, 6 after accept
    tbl[12] = '{1, 0, 0, 0, 0, 4'b0010, 4'b0010, 1, 0}; // ch2 now OFF
    tbl[13] = '{1, 0, 0, 0, 0, 4'b0011, 4'b0011, 1, 0}; // ch0 toggles high
    tbl[14] = '{1, 0, 0, 0, 0, 4'b0011, 4'b0010, 1, 0};

    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    #2;
    check("rst_op", 32'(op), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_rdy", 32'(cfg_ready), 32'h0);
    check("rst_err", 32'(cfg_err), 32'h0);
    step();
    step();
    check("rst_rdy_clk", 32'(cfg_ready), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].en, tbl[i].v, tbl[i].ch, tbl[i].dv, tbl[i].md);
      step();
      check($sformatf("row%0d_op", i), 32'(op), 32'(tbl[i].op));
      check($sformatf("row%0d_tick", i), 32'(tick), 32'(tbl[i].tick));
      check($sformatf("row%0d_rdy", i), 32'(cfg_ready), 32'(tbl[i].rdy));
      check($sformatf("row%0d_err", i), 32'(cfg_err), 32'(tbl[i].err));
    end

    // Enable freeze: ch0 sits at cnt=1 with op[0]=1.
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("frz%0d_op0", i), 32'(op[0]), 32'h1);
      check($sformatf("frz%0d_tick", i), 32'(tick), 32'h0);
    end
    en = 1'b1;
    step();
    check("res0_tick0", 32'(tick[0]), 32'h0);
    check("res0_tick1", 32'(tick[1]), 32'h1);
    step();
    check("res1_tick0", 32'(tick[0]), 32'h0);
    step();
    check("res2_tick0", 32'(tick[0]), 32'h1);
    check("res2_op0", 32'(op[0]), 32'h0);

    // Reconfigure ch0 on its terminal-count edge.
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("pre%0d_tick0", i), 32'(tick[0]), 32'h0);
    end
    drive(1, 1, 0, 3, 1);
    step();
    check("rcf_tick0", 32'(tick[0]), 32'h0);
    check("rcf_op0", 32'(op[0]), 32'h0);
    check("rcf_tick1", 32'(tick[1]), 32'h1);
    check("rcf_rdy", 32'(cfg_ready), 32'h0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst%0d_tick0", i), 32'(tick[0]), 32'h0);
      check($sformatf("rst%0d_tick1", i), 32'(tick[1]), 32'h1);
    end
    step();
    check("rcf_fire_tick0", 32'(tick[0]), 32'h1);
    check("rcf_fire_op0", 32'(op[0]), 32'h1);

    // cfg_ch == CH boundary: rejected, no channel touched.
    drive(1, 1, 4, 0, 2);
    step();
    check("b4_err", 32'(cfg_err), 32'h1);
    check("b4_op", 32'(op), 32'b0011);
    check("b4_tick3", 32'(tick[3]), 32'h0);
    drive(1, 0, 0, 0, 0);
    step();
    check("b4_err_clr", 32'(cfg_err), 32'h0);
    check("b4_rdy", 32'(cfg_ready), 32'h1);
    check("b4_op0", 32'(op[0]), 32'h1);

    // Asynchronous reset between edges, with a request pending.
    drive(1, 1, 3, 2, 1);
    #3;
    reset = 1'b1;
    #1;
    check("arst_op", 32'(op), 32'h0);
    check("arst_tick", 32'(tick), 32'h0);
    check("arst_rdy", 32'(cfg_ready), 32'h0);
    check("arst_err", 32'(cfg_err), 32'h0);
    step();
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("arel_rdy", 32'(cfg_ready), 32'h1);
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("off%0d_op", i), 32'(op), 32'h0);
      check($sformatf("off%0d_tick", i), 32'(tick), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/multi_div_gen.md
MULTI_DIV_GEN -- requirements
Module: multi_div_gen

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent output channels, 1..16.
REQ-002 SHALL have parameter W, default 8: divider register width, 2..16.
REQ-003 SHALL have parameter CW, default 2: channel-select width; SHALL be at least clog2(CH), minimum 1.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1  global count enable.
REQ-007 SHALL have port cfg_valid  input  1  config request.
REQ-008 SHALL have port cfg_ready  output  1  block can accept config.
REQ-009 SHALL have port cfg_ch  input  CW  target channel.
REQ-010 SHALL have port cfg_div  input  W  terminal count.
REQ-011 SHALL have port cfg_mode  input  2  channel mode: 00 OFF, 01 TOGGLE, 10 PULSE, 11 ONESHOT.
REQ-012 SHALL have port op  output  CH  per-channel waveform output, registered.
REQ-013 SHALL have port tick  output  CH  per-channel one-cycle terminal-count strobe, registered.
REQ-014 SHALL have port cfg_err  output  1  one-cycle strobe flagging an accepted config with cfg_ch >= CH.

Function
REQ-015 Each channel SHALL hold registers cnt[W], div[W] and mode[2].
REQ-016 Accept SHALL be cfg_valid && cfg_ready sampled at a clk edge.
REQ-017 cfg_ready SHALL go 0 for exactly the one cycle after each accept, then return to 1; maximum config rate is one accept per 2 cycles.
REQ-018 On accept with cfg_ch < CH, the target channel SHALL load div <= cfg_div, mode <= cfg_mode, cnt <= 0, op <= 0, tick <= 0 in that edge.
REQ-019 On accept with cfg_ch >= CH, no channel state SHALL change, and cfg_err SHALL be 1 for the following cycle.
REQ-020 A channel is active when en=1 and mode != OFF.
REQ-021 An active channel not being configured SHALL count cnt 0..div; at cnt==div, cnt SHALL wrap to 0 and the terminal event fires.
REQ-022 The terminal-event period SHALL be div+1 cycles.
REQ-023 With div=0, the terminal event SHALL fire every enabled cycle.
REQ-024 On a terminal event, tick SHALL be 1 for exactly the next cycle; otherwise tick SHALL be 0.
REQ-025 TOGGLE: op SHALL invert on each terminal event, giving period 2*(div+1) cycles with 50% duty.
REQ-026 PULSE: op SHALL equal tick.
REQ-027 ONESHOT: on the first terminal event, op and tick SHALL pulse high for one cycle and mode SHALL become OFF in the same edge.
REQ-028 OFF: cnt SHALL be held at 0, and op and tick SHALL be 0.
REQ-029 en=0: cnt and op SHALL hold their values, tick SHALL be 0, and config SHALL still be accepted.
REQ-030 Config to a channel on the same edge as its terminal event: config SHALL win, with no tick and no op change beyond REQ-018.
REQ-031 Channels SHALL be fully independent; configuring one channel SHALL NOT disturb the phase of the others.

Reset
REQ-032 While reset=1, every cnt, div, op, tick and cfg_err SHALL be 0, every mode SHALL be OFF, and cfg_ready SHALL be 0, independent of clk.
REQ-033 cfg_ready SHALL be 1 from the first clk edge after reset deassertion.
REQ-034 Reset asserted mid-count or mid-handshake SHALL abort immediately to the REQ-032 state; no partial config SHALL survive.

Verification
REQ-035 Reset released; config ch0 div=3 mode=TOGGLE, en=1 -> op[0] toggles every 4 cycles (period 8), tick[0] pulses every 4 cycles.
REQ-036 Config ch1 div=0 mode=PULSE -> tick[1]=op[1]=1 every cycle; config ch2 div=5 ONESHOT -> one op[2] pulse 6 cycles after accept, then 0 forever.
REQ-037 Back-to-back cfg_valid -> cfg_ready low on alternate cycles, only every second request accepted; cfg_ch=7 with CH=4 -> cfg_err one cycle, all channels unchanged.
REQ-038 en dropped for 10 cycles mid-count on ch0 -> cnt and op frozen, tick 0; en restored -> terminal event resumes exactly where it left off.
REQ-039 Reconfigure ch0 on its terminal-count edge -> no tick, op[0]=0, cnt restarts at 0; ch1 phase unaffected.
REQ-040 Assert reset asynchronously between edges mid-operation -> all outputs 0 immediately, cfg_ready 0, and all channels OFF after release.
